l2_port_arbiter: RTL and testbench
==================================

L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, request/L2 address width.
REQ-002 Parameter DATA_WIDTH, default 32, L2 data width.
REQ-003 Parameter MISS_PENALTY, default 4, extra stall cycles after an L2 miss; legal range 1..255.
REQ-004 Parameter CNT_WIDTH, default 16, width of statistics counters.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester N has a read pending.
- req0_addr / req1_addr  in  ADDR_WIDTH  requester N read address.
- req0_ready / req1_ready  out  1  request N accepted this cycle.
- resp0_valid / resp1_valid  out  1  one-cycle response strobe to requester N.
- resp0_data / resp1_data  out  DATA_WIDTH  response data.
- resp0_hit / resp1_hit  out  1  L2 hit flag for that response.
- l2_read  out  1  read strobe to the L2 cache.
- l2_addr  out  ADDR_WIDTH  address to the L2 cache.
- l2_read_data  in  DATA_WIDTH  L2 registered data, valid the cycle after the L2 samples l2_read.
- l2_hit  in  1  L2 registered hit, same timing as l2_read_data.
- busy  out  1  high whenever state is not IDLE.
- hit_count / miss_count  out  CNT_WIDTH  completed L2 hits / misses.

Function
REQ-006 FSM states: IDLE, ISSUE, WAIT, PENALTY, RESP; one transaction in flight at most.
REQ-007 IDLE: reqN_ready = (state==IDLE) & reqN_valid & granted(N), combinational; at most one ready high per cycle.
REQ-008 Arbitration is round-robin: with both valid, the port not granted last wins; with one valid, it wins regardless of pointer.
REQ-009 On handshake edge E0: latch address and port ID, update RR pointer to the winner, go to ISSUE.
REQ-010 ISSUE: l2_read=1 and l2_addr=latched address for exactly one cycle; next state WAIT.
REQ-011 WAIT: at edge E2, capture l2_read_data and l2_hit; hit goes to RESP, miss goes to PENALTY with counter loaded to MISS_PENALTY.
REQ-012 PENALTY: counter decrements once per cycle; go to RESP on the edge where it reaches 1 (exactly MISS_PENALTY cycles in PENALTY).
REQ-013 RESP: respN_valid=1 for the latched port only, one cycle, with captured data and hit; then IDLE.
REQ-014 Latency from E0 to resp_valid high: 3 cycles on hit, 3+MISS_PENALTY cycles on miss.
REQ-015 Outside ISSUE, l2_read=0; l2_addr holds its last value.
REQ-016 respN_data/respN_hit hold their last value when respN_valid=0.
REQ-017 A new request is accepted no earlier than the cycle after RESP, because ready is low in non-IDLE states.
REQ-018 hit_count / miss_count increment by 1 at the WAIT capture edge and saturate at all-ones.
REQ-019 A requester deasserting valid without ready causes no side effects.

Reset
REQ-020 rst_n low forces immediately, at any time including mid-transaction: state IDLE, RR pointer favouring port 0, all outputs 0, counters 0, latched data/hit/address 0.
REQ-021 Any in-flight transaction is dropped silently on reset; no response is emitted after reset release.

Structure
REQ-022 State encodings and default widths live in shared package cache_pkg.
REQ-023 The round-robin grant logic is sub-module rr_arbiter2: 2 requests plus a last-grant bit in, one-hot grant out.

Verification
REQ-024 Scenario 1: port0 reads 0x040 on a cold L2 -> l2_read pulses once, resp0_valid 7 cycles after E0, resp0_hit=0, data 0xDEADBEEF, miss_count=1.
REQ-025 Scenario 2: port0 repeats 0x040 -> resp0_valid 3 cycles after E0, resp0_hit=1, data 0xDEADBEEF, hit_count=1.
REQ-026 Scenario 3: both ports valid continuously from reset -> grants alternate 0,1,0,1; neither port starves.
REQ-027 Scenario 4: both ports valid, addresses 0x000 and 0x200 -> exactly one ready per cycle, responses are routed to the correct port, and resp1_valid is never high for a port0 request.
REQ-028 Scenario 5: rst_n pulsed low during PENALTY -> busy=0 and all outputs 0 immediately; no resp_valid follows.
REQ-029 Scenario 6: hit_count preloaded near saturation with CNT_WIDTH=2, four hits -> hit_count stays at 3.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the L2 port arbiter.
//   - Default widths for the address, data and statistics counter paths.
//   - FSM state encodings. They are plain localparams so that older
//     tools and assertion files can use them directly.
package cache_pkg;

  localparam int ADDR_WIDTH_DEF   = 11;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int MISS_PENALTY_DEF = 4;
  localparam int CNT_WIDTH_DEF    = 16;

  // Wide enough to hold any MISS_PENALTY in 1..255.
  localparam int PEN_WIDTH = 8;

  localparam int STATE_WIDTH = 3;
  localparam logic [STATE_WIDTH-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_WIDTH-1:0] ST_ISSUE   = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ST_WAIT    = 3'd2;
  localparam logic [STATE_WIDTH-1:0] ST_PENALTY = 3'd3;
  localparam logic [STATE_WIDTH-1:0] ST_RESP    = 3'd4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant logic (purely combinational).
//   req_i[1:0]    : request vector, bit N = port N wants service
//   last_grant_i  : port that won the previous arbitration (0 or 1)
//   gnt_o[1:0]    : one-hot grant, all-zero when nothing is requested
// When both ports request, the port that did not win last time is granted.
// When only one port requests, it is granted whatever the pointer says.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!req_i[1] || last_grant_i)) begin
      gnt_o[0] = 1'b1;
    end else if (req_i[1]) begin
      gnt_o[1] = 1'b1;
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Arbitrates two read requesters onto a single L2 cache read port.
// One transaction is in flight at a time:
//   IDLE -> ISSUE (one-cycle l2_read) -> WAIT (capture registered L2 reply)
//        -> [PENALTY for MISS_PENALTY cycles on a miss] -> RESP -> IDLE
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/addr/ready       requester N read request handshake
//   respN_valid/data/hit        one-cycle response strobe to requester N
//   l2_read, l2_addr            read strobe and address to the L2
//   l2_read_data, l2_hit        L2 reply, valid the cycle after l2_read
//   busy                        high whenever the FSM is not IDLE
//   hit_count, miss_count       saturating statistics of completed lookups
//
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high. ready is only ever raised in IDLE, for the one
// port chosen by the round-robin arbiter, so at most one transfer happens per
// cycle. A requester may drop valid before ready without any effect. The
// response side has no back-pressure: respN_valid is a single-cycle strobe.
module l2_port_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int MISS_PENALTY = MISS_PENALTY_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic                  resp0_valid,
  output logic [DATA_WIDTH-1:0] resp0_data,
  output logic                  resp0_hit,
  output logic                  resp1_valid,
  output logic [DATA_WIDTH-1:0] resp1_data,
  output logic                  resp1_hit,
  output logic                  l2_read,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  input  logic [DATA_WIDTH-1:0] l2_read_data,
  input  logic                  l2_hit,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [PEN_WIDTH-1:0] PEN_LOAD = PEN_WIDTH'(MISS_PENALTY);

  logic [STATE_WIDTH-1:0] state_q, state_d;
  logic [PEN_WIDTH-1:0]   pen_q, pen_d;
  logic                   last_q;     // port granted last (1 = port 1)
  logic                   port_q;     // port owning the current transaction
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   hit_q;
  logic [CNT_WIDTH-1:0]   hit_cnt_q, miss_cnt_q;
  logic [DATA_WIDTH-1:0]  resp0_data_q, resp1_data_q;
  logic                   resp0_hit_q, resp1_hit_q;

  logic [1:0]            gnt;
  logic                  idle;
  logic                  accept;
  logic                  load_resp;
  logic [DATA_WIDTH-1:0] resp_data_src;
  logic                  resp_hit_src;

  rr_arbiter2 u_rr (
    .req_i        ({req1_valid, req0_valid}),
    .last_grant_i (last_q),
    .gnt_o        (gnt)
  );

  assign idle = (state_q == ST_IDLE);

  // rst_n gates ready so that every output is low while reset is held,
  // even if a requester keeps valid asserted through reset.
  assign req0_ready = rst_n & idle & gnt[0];
  assign req1_ready = rst_n & idle & gnt[1];
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    state_d = state_q;
    pen_d   = pen_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (l2_hit) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_PENALTY;
          pen_d   = PEN_LOAD;
        end
      end
      ST_PENALTY: begin
        // Loaded with MISS_PENALTY, leaves on the edge where it reads 1:
        // exactly MISS_PENALTY cycles are spent here.
        if (pen_q == PEN_WIDTH'(1)) begin
          state_d = ST_RESP;
        end else begin
          pen_d = pen_q - PEN_WIDTH'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The per-port response registers are loaded only on entry to RESP, so
  // respN_data/hit keep their previous value while the strobe is low. On the
  // hit path RESP is entered straight from WAIT, before data_q is written,
  // so the L2 reply is forwarded directly in that case.
  assign load_resp     = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign resp_data_src = (state_q == ST_WAIT) ? l2_read_data : data_q;
  assign resp_hit_src  = (state_q == ST_WAIT) ? l2_hit       : hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pen_q        <= '0;
      last_q       <= 1'b1;  // port 0 wins the first contested arbitration
      port_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      hit_q        <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      resp0_data_q <= '0;
      resp1_data_q <= '0;
      resp0_hit_q  <= 1'b0;
      resp1_hit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pen_q   <= pen_d;

      if (accept) begin
        addr_q <= req1_ready ? req1_addr : req0_addr;
        port_q <= req1_ready;
        last_q <= req1_ready;
      end

      if (state_q == ST_WAIT) begin
        data_q <= l2_read_data;
        hit_q  <= l2_hit;
        if (l2_hit) begin
          if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_ONE;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_ONE;
        end
      end

      if (load_resp) begin
        if (port_q) begin
          resp1_data_q <= resp_data_src;
          resp1_hit_q  <= resp_hit_src;
        end else begin
          resp0_data_q <= resp_data_src;
          resp0_hit_q  <= resp_hit_src;
        end
      end
    end
  end

  assign l2_read     = (state_q == ST_ISSUE);
  assign l2_addr     = addr_q;
  assign busy        = !idle;
  assign resp0_valid = (state_q == ST_RESP) && !port_q;
  assign resp1_valid = (state_q == ST_RESP) &&  port_q;
  assign resp0_data  = resp0_data_q;
  assign resp1_data  = resp1_data_q;
  assign resp0_hit   = resp0_hit_q;
  assign resp1_hit   = resp1_hit_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter. A second instance with 2-bit counters shares
// all inputs with the main instance so counter saturation can be observed.
module tb_l2_port_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int MP = 4;
  localparam int CW = 16;
  localparam int W  = DW + 2;  // {port, hit, data}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic          req0_ready, req1_ready;
  logic          resp0_valid, resp1_valid, resp0_hit, resp1_hit;
  logic [DW-1:0] resp0_data, resp1_data;
  logic          l2_read;
  logic [AW-1:0] l2_addr;
  logic [DW-1:0] l2_read_data = '0;
  logic          l2_hit = 1'b0;
  logic          busy;
  logic [CW-1:0] hit_count, miss_count;

  logic          s_req0_ready, s_req1_ready, s_resp0_valid, s_resp1_valid;
  logic          s_resp0_hit, s_resp1_hit, s_l2_read, s_busy;
  logic [DW-1:0] s_resp0_data, s_resp1_data;
  logic [AW-1:0] s_l2_addr;
  logic [1:0]    s_hit_count, s_miss_count;

  l2_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MISS_PENALTY(MP), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_hit(resp0_hit),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_hit(resp1_hit),
    .l2_read(l2_read), .l2_addr(l2_addr), .l2_read_data(l2_read_data), .l2_hit(l2_hit),
    .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
  );

  l2_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MISS_PENALTY(MP), .CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(s_req1_ready),
    .resp0_valid(s_resp0_valid), .resp0_data(s_resp0_data), .resp0_hit(s_resp0_hit),
    .resp1_valid(s_resp1_valid), .resp1_data(s_resp1_data), .resp1_hit(s_resp1_hit),
    .l2_read(s_l2_read), .l2_addr(s_l2_addr), .l2_read_data(l2_read_data), .l2_hit(l2_hit),
    .busy(s_busy), .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  // ---------------- L2 environment ----------------
  function automatic logic [DW-1:0] l2_data_fn(input logic [AW-1:0] a);
    return (a == 11'h040) ? 32'hDEADBEEF : (32'hC0DE0000 | {{(DW-AW){1'b0}}, a});
  endfunction

  bit   env_present [0:(1<<AW)-1];
  logic cold_req = 1'b0;

  always @(posedge clk) begin
    if (cold_req) begin
      for (int i = 0; i < (1 << AW); i++) env_present[i] <= 1'b0;
    end else if (l2_read) begin
      l2_read_data         <= l2_data_fn(l2_addr);
      l2_hit               <= env_present[l2_addr];
      env_present[l2_addr] <= 1'b1;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  bit ref_last;           // port granted last
  bit ref_present[int];   // addresses the L2 has already seen
  int ref_hits, ref_misses;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_last   = 1'b1;
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  task automatic model_txn(input bit v0, input bit v1,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           output bit port, output bit hit, output int lat,
                           output logic [DW-1:0] data);
    logic [AW-1:0] a;
    port     = (v0 && v1) ? !ref_last : v1;
    ref_last = port;
    a        = port ? a1 : a0;
    hit      = ref_present.exists(int'(a));
    ref_present[int'(a)] = 1'b1;
    lat      = hit ? 3 : 3 + MP;
    data     = l2_data_fn(a);
    if (hit) ref_hits++; else ref_misses++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cold_l2();
    cold_req = 1'b1;
    step();
    cold_req = 1'b0;
    ref_present.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {req0_ready, req1_ready, resp0_valid, resp1_valid,
                           resp0_hit, resp1_hit, l2_read, busy}, 0);
    check({tag, "_resp0_data"}, resp0_data, 0);
    check({tag, "_resp1_data"}, resp1_data, 0);
    check({tag, "_l2_addr"}, l2_addr, 0);
    check({tag, "_counters"}, {hit_count, miss_count}, 0);
  endtask

  // Entry and exit: 1 time unit after a rising edge, DUT idle, valids low.
  task automatic do_txn(input bit v0, input bit v1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input bit e_port, input bit e_hit, input int e_lat,
                        input logic [DW-1:0] e_data, input bit noise);
    bit           seen;
    int           nreads;
    logic [W-1:0] exp_item, act_item;
    req0_valid = v0;
    req1_valid = v1;
    req0_addr  = a0;
    req1_addr  = a1;
    @(negedge clk);
    check("busy_before_req", busy, 0);
    check("ready_pair", {req1_ready, req0_ready}, e_port ? 2'b10 : 2'b01);
    step();  // handshake edge E0
    exp_q.push_back({e_port, e_hit, e_data});
    seen   = 1'b0;
    nreads = 0;
    for (int k = 1; k <= 3 + MP + 4 && !seen; k++) begin
      if (noise && k <= 2) begin
        req0_valid = 1'($urandom_range(0, 1));
        req1_valid = 1'($urandom_range(0, 1));
        req0_addr  = AW'($urandom);
        req1_addr  = AW'($urandom);
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
      if (l2_read) nreads++;
      if (k == 1) check("l2_addr", l2_addr, e_port ? a1 : a0);
      if (noise && k <= 2) check("ready_while_busy", {req1_ready, req0_ready}, 0);
      if (resp0_valid || resp1_valid) begin
        seen = 1'b1;
        check("resp_latency", k, e_lat);
        check("resp_both_valid", resp0_valid & resp1_valid, 0);
        exp_item = exp_q.pop_front();
        act_item = resp1_valid ? {1'b1, resp1_hit, resp1_data} : {1'b0, resp0_hit, resp0_data};
        check("resp_port_hit_data", act_item, exp_item);
      end
      step();
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: no response, expected one after %0d cycles", e_lat);
      void'(exp_q.pop_front());
    end
    check("l2_read_pulses", nreads, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            v0;
    bit            v1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    bit            port;
    bit            hit;
    int            lat;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            r_port, r_hit;
    int            r_lat;
    logic [DW-1:0] r_data;
    bit            v0, v1;
    logic [AW-1:0] a0, a1;
    int            grants[$];
    int            resps[$];
    int            resp_cycles;

    //          v0 v1  a0      a1      port hit lat     data
    vecs[0] = '{1, 0, 11'h040, 11'h000, 0, 0, 3 + MP, 32'hDEADBEEF};  // cold miss
    vecs[1] = '{1, 0, 11'h040, 11'h000, 0, 1, 3,      32'hDEADBEEF};  // repeat hits
    vecs[2] = '{1, 1, 11'h000, 11'h200, 1, 0, 3 + MP, 32'hC0DE0200};
    vecs[3] = '{1, 1, 11'h000, 11'h200, 0, 0, 3 + MP, 32'hC0DE0000};
    vecs[4] = '{1, 1, 11'h000, 11'h200, 1, 1, 3,      32'hC0DE0200};
    vecs[5] = '{1, 1, 11'h000, 11'h200, 0, 1, 3,      32'hC0DE0000};
    vecs[6] = '{0, 1, 11'h000, 11'h040, 1, 1, 3,      32'hDEADBEEF};
    vecs[7] = '{0, 1, 11'h000, 11'h123, 1, 0, 3 + MP, 32'hC0DE0123};  // lone port 1 wins

    // Reset state, sampled while reset is held.
    #2;
    check_all_zero("reset");
    do_reset();

    // Table-driven transactions (4 hits, 4 misses).
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].a1,
             vecs[i].port, vecs[i].hit, vecs[i].lat, vecs[i].data, 1'b0);
    end
    @(negedge clk);
    check("hit_count", hit_count, 4);
    check("miss_count", miss_count, 4);
    check("sat_hit_count", s_hit_count, 3);
    check("sat_miss_count", s_miss_count, 3);
    step();

    // Reset in the middle of a miss penalty.
    req0_valid = 1'b1;
    req0_addr  = 11'h050;
    step();           // E0
    req0_valid = 1'b0;
    step();           // ISSUE -> WAIT
    step();           // WAIT -> PENALTY
    step();           // second PENALTY cycle
    check("busy_in_penalty", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    step();
    step();
    rst_n = 1'b1;
    model_reset();
    resp_cycles = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid || busy) resp_cycles++;
      step();
    end
    check("no_resp_after_reset", resp_cycles, 0);

    // Both ports valid continuously from reset: grants alternate.
    cold_l2();
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_addr  = 11'h000;
    req1_addr  = 11'h200;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 60 && resps.size() < 4; k++) begin
      @(negedge clk);
      check("ready_one_hot", req0_ready & req1_ready, 0);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (resp0_valid) begin
        resps.push_back(0);
        check("contend_resp0_data", resp0_data, 32'hC0DE0000);
      end
      if (resp1_valid) begin
        resps.push_back(1);
        check("contend_resp1_data", resp1_data, 32'hC0DE0200);
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("grant_count", grants.size(), 4);
    check("resp_count", resps.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("grant_order", (i < grants.size()) ? grants[i] : -1, i % 2);
      check("resp_routing", (i < resps.size()) ? resps[i] : -1, i % 2);
    end
    step();
    step();

    // Randomized transactions against the reference model.
    do_reset();
    cold_l2();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(1, 3))
        1: begin v0 = 1'b1; v1 = 1'b0; end
        2: begin v0 = 1'b0; v1 = 1'b1; end
        default: begin v0 = 1'b1; v1 = 1'b1; end
      endcase
      a0 = AW'($urandom_range(0, 7) << 4);
      a1 = AW'(11'h400 | ($urandom_range(0, 3) << 4));
      if ($urandom_range(0, 3) == 0) a1 = a0;  // both ports to one line
      model_txn(v0, v1, a0, a1, r_port, r_hit, r_lat, r_data);
      do_txn(v0, v1, a0, a1, r_port, r_hit, r_lat, r_data, 1'b1);
    end
    @(negedge clk);
    check("rand_hit_count", hit_count, ref_hits);
    check("rand_miss_count", miss_count, ref_misses);
    check("rand_sat_hit", s_hit_count, (ref_hits > 3) ? 3 : ref_hits);
    check("rand_sat_miss", s_miss_count, (ref_misses > 3) ? 3 : ref_misses);
    check("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
